// File: rtl/positadd_arbiter_pkg.sv
// posit_arb_pkg: shared types and helpers for the posit adder arbiter.
//   arb_state_t    - arbiter FSM state encoding
//   MAX_NUM_REQ    - largest supported requester count
//   idx_width()    - grant-index width for a given requester count
//   NAR_PATTERN()  - posit NaR bit pattern (1 << (n-1)) for width n <= 64
package posit_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int MAX_NUM_REQ = 8;

    function automatic int idx_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Returned 64 bits wide; callers slice the low n bits.
    function automatic logic [63:0] NAR_PATTERN(input int n);
        return 64'd1 << (n - 1);
    endfunction

endpackage

// File: rtl/positadd_arbiter_if.sv
// positadd_arbiter_if: requester handshakes plus the shared adder bus.
//   req_valid/req_ready/req_in1/req_in2  - per-requester operand handshake
//   resp_valid/resp_ready                - per-requester result handshake
//   resp_result/resp_inf/resp_zero/resp_err - shared result bus
//   add_in1/add_in2/add_start            - adder launch
//   add_result/add_inf/add_zero/add_done - adder completion
// Modports: slave = arbiter view, master = requesters + adder view.
interface positadd_arbiter_if #(
    parameter int N       = 32,
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*N-1:0] req_in1;
    logic [NUM_REQ*N-1:0] req_in2;
    logic [NUM_REQ-1:0]   resp_valid;
    logic [NUM_REQ-1:0]   resp_ready;
    logic [N-1:0]         resp_result;
    logic                 resp_inf;
    logic                 resp_zero;
    logic                 resp_err;
    logic [N-1:0]         add_in1;
    logic [N-1:0]         add_in2;
    logic                 add_start;
    logic [N-1:0]         add_result;
    logic                 add_inf;
    logic                 add_zero;
    logic                 add_done;

    modport slave (
        input  req_valid, req_in1, req_in2, resp_ready,
               add_result, add_inf, add_zero, add_done,
        output req_ready, resp_valid, resp_result, resp_inf, resp_zero, resp_err,
               add_in1, add_in2, add_start
    );

    modport master (
        output req_valid, req_in1, req_in2, resp_ready,
               add_result, add_inf, add_zero, add_done,
        input  req_ready, resp_valid, resp_result, resp_inf, resp_zero, resp_err,
               add_in1, add_in2, add_start
    );
endinterface

// File: rtl/positadd_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick.
//   req   in  NUM_REQ  request vector
//   ptr   in  IDX_W    highest-priority index for this pick
//   grant out NUM_REQ  one-hot winner (zero when no request)
//   idx   out IDX_W    winner index
//   any   out 1        at least one request present
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);
    int c;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        c     = 0;
        // Walk the requesters starting at ptr, wrapping; first hit wins.
        for (int k = 0; k < NUM_REQ; k++) begin
            c = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[c]) begin
                any      = 1'b1;
                grant[c] = 1'b1;
                idx      = IDX_W'(c);
            end
        end
    end
endmodule

// File: rtl/positadd_arbiter.sv
// positadd_arbiter: shares one posit adder among NUM_REQ requesters.
// One operation in flight at a time, round-robin grant order.
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous reset, active low
//   bus    slave modport of positadd_arbiter_if (requester and adder buses)
// Parameters: N posit width, ES exponent size (not used by the logic),
//   NUM_REQ requesters (2..8), MAX_LAT watchdog limit in cycles.
// Optional feature macro POSITADD_ARB_WATCHDOG_EN: aborts a WAIT that lasts
//   MAX_LAT cycles with a NaR result and resp_err=1. Without it resp_err is 0
//   and WAIT is unbounded.
module positadd_arbiter
    import posit_arb_pkg::*;
#(
    parameter int N       = 32,
    parameter int ES      = 2,
    parameter int NUM_REQ = 4,
    parameter int MAX_LAT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    positadd_arbiter_if.slave bus
);
    localparam int          IDX_W    = idx_width(NUM_REQ);
    localparam logic [63:0] NAR_FULL = NAR_PATTERN(N);

    if (NUM_REQ < 2 || NUM_REQ > MAX_NUM_REQ || N > 64 || ES < 0 || ES >= N || MAX_LAT < 1)
    begin : g_param_check
        $error("positadd_arbiter: parameter out of range");
    end

    arb_state_t         state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   gnt_idx;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_oh;
    logic               pick_any;
    logic               accept;
    logic               resp_hs;
    logic [NUM_REQ-1:0] resp_vld;
    logic [N-1:0]       op1;
    logic [N-1:0]       op2;
    logic [N-1:0]       res;
    logic               res_inf;
    logic               res_zero;
    logic               start;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (pick_oh),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Gated by rst_n so no requester sees ready while reset is held.
    assign bus.req_ready = (rst_n && state == IDLE) ? pick_oh : '0;
    assign accept        = rst_n && (state == IDLE) && pick_any;
    // Only the granted requester's ready bit can complete the response.
    assign resp_hs       = (state == RESP) && bus.resp_ready[gnt_idx];

    assign bus.add_in1     = op1;
    assign bus.add_in2     = op2;
    assign bus.add_start   = start;
    assign bus.resp_valid  = resp_vld;
    assign bus.resp_result = res;
    assign bus.resp_inf    = res_inf;
    assign bus.resp_zero   = res_zero;

`ifdef POSITADD_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(MAX_LAT + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            err_q;
    assign bus.resp_err = err_q;
`else
    assign bus.resp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            gnt_idx  <= '0;
            start    <= 1'b0;
            op1      <= '0;
            op2      <= '0;
            resp_vld <= '0;
            res      <= '0;
            res_inf  <= 1'b0;
            res_zero <= 1'b0;
`ifdef POSITADD_ARB_WATCHDOG_EN
            wd_cnt   <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op1     <= bus.req_in1[int'(pick_idx)*N +: N];
                        op2     <= bus.req_in2[int'(pick_idx)*N +: N];
                        gnt_idx <= pick_idx;
                        rr_ptr  <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                        start   <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    start <= 1'b0;
`ifdef POSITADD_ARB_WATCHDOG_EN
                    wd_cnt <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.add_done) begin
                        res      <= bus.add_result;
                        res_inf  <= bus.add_inf;
                        res_zero <= bus.add_zero;
                        resp_vld <= NUM_REQ'(1) << gnt_idx;
                        state    <= RESP;
                    end
`ifdef POSITADD_ARB_WATCHDOG_EN
                    // Abort after MAX_LAT cycles in WAIT: NaR flagged as inf.
                    else if (wd_cnt == WD_W'(MAX_LAT - 1)) begin
                        res      <= NAR_FULL[N-1:0];
                        res_inf  <= 1'b1;
                        res_zero <= 1'b0;
                        err_q    <= 1'b1;
                        resp_vld <= NUM_REQ'(1) << gnt_idx;
                        state    <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (resp_hs) begin
                        resp_vld <= '0;
`ifdef POSITADD_ARB_WATCHDOG_EN
                        err_q    <= 1'b0;
`endif
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_positadd_arbiter.sv
// tb_positadd_arbiter: testbench for positadd_arbiter with a fixed-latency
// stub adder. The stub returns the known posit sums for the reference vectors
// and a plain integer sum otherwise; flags follow from the returned pattern.
module tb_positadd_arbiter;
    localparam int          N       = 32;
    localparam int          NR      = 4;
    localparam int          MAX_LAT = 16;
    localparam int          L       = 4;
    localparam logic [31:0] NAR     = 32'h8000_0000;

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        inf;
        logic        zero;
    } vec_t;

    logic clk       = 1'b0;
    logic rst_n     = 1'b1;
    int   cyc       = 0;
    int   nvec      = 0;
    int   nmis      = 0;
    int   stub_cnt  = 0;
    logic stub_hang = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    positadd_arbiter_if #(.N(N), .NUM_REQ(NR)) bus ();

    positadd_arbiter #(
        .N       (N),
        .ES      (2),
        .NUM_REQ (NR),
        .MAX_LAT (MAX_LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] stub_fn(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h5AD9_A053 && b == 32'hB36A_8CB6) return 32'h5768_8701;
        if (a == 32'hFDEF_5956 && b == 32'hB1F6_85E1) return 32'hB1F6_8599;
        return a + b;
    endfunction

    function automatic logic [NR-1:0] onehot(input int i);
        logic [NR-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Stub adder: done pulses in the 6th cycle after the start cycle.
    logic        stub_done;
    logic [31:0] stub_res;
    always @(posedge clk) begin
        if (bus.add_start) stub_cnt <= L + 2;
        else if (stub_cnt > 0) stub_cnt <= stub_cnt - 1;
    end
    assign stub_done      = (stub_cnt == 1) && !stub_hang;
    assign stub_res       = stub_fn(bus.add_in1, bus.add_in2);
    assign bus.add_done   = stub_done;
    assign bus.add_result = stub_done ? stub_res : 32'hDEAD_BEEF;
    assign bus.add_inf    = stub_done && (stub_res == NAR);
    assign bus.add_zero   = stub_done && (stub_res == 32'h0);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.req_valid[i]       = 1'b1;
        bus.req_in1[i*N +: N]  = a;
        bus.req_in2[i*N +: N]  = b;
    endtask

    // Returns just after the accept edge; acc is the accept cycle number.
    task automatic wait_accept(input int i, output int acc, output bit ok);
        ok  = 1'b0;
        acc = -1;
        for (int k = 0; k < 100; k++) begin
            #1;
            if (bus.req_ready[i]) begin
                acc = cyc;
                ok  = 1'b1;
                tick();
                return;
            end
            tick();
        end
        chk($sformatf("accept_timeout_req%0d", i), ok, 1);
    endtask

    // Waits (bounded) until any resp_valid bit is high; t is the cycle number.
    task automatic wait_resp(output int t);
        t = -1;
        for (int k = 0; k < 200; k++) begin
            if (bus.resp_valid != '0) begin
                t = cyc;
                return;
            end
            tick();
        end
        chk("resp_timeout", t, 0);
    endtask

    task automatic do_reset();
        bus.req_valid  = '0;
        bus.resp_ready = '0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t          vecs[5];
    int            acc, acc2, hs, t, t_start, starts, ngr, ptr, w, d;
    bit            ok, hold_ok, multi, late_bad;
    int            order[8];
    logic [31:0]   r0, ea, eb, er;
    logic [31:0]   fa[NR];
    logic [31:0]   fb[NR];
    logic [NR-1:0] mask;

    initial begin
        bus.req_valid  = '0;
        bus.req_in1    = '0;
        bus.req_in2    = '0;
        bus.resp_ready = '0;
        vecs[0] = '{0, 32'h5AD9_A053, 32'hB36A_8CB6, 32'h5768_8701, 1'b0, 1'b0};
        vecs[1] = '{1, 32'hFDEF_5956, 32'hB1F6_85E1, 32'hB1F6_8599, 1'b0, 1'b0};
        vecs[2] = '{2, 32'h0000_0005, 32'hFFFF_FFFB, 32'h0000_0000, 1'b0, 1'b1};
        vecs[3] = '{3, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0};
        vecs[4] = '{0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0};

        // Reset state, with every requester asking.
        #1 rst_n = 1'b0;
        bus.req_valid = '1;
        #1;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_add_start", bus.add_start, 0);
        chk("rst_add_in1", bus.add_in1, 0);
        chk("rst_add_in2", bus.add_in2, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_result", bus.resp_result, 0);
        chk("rst_resp_inf", bus.resp_inf, 0);
        chk("rst_resp_zero", bus.resp_zero, 0);
        chk("rst_resp_err", bus.resp_err, 0);
        bus.req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven single operations with latency checks.
        for (int v = 0; v < 5; v++) begin
            bus.req_valid = '0;
            set_req(vecs[v].idx, vecs[v].a, vecs[v].b);
            wait_accept(vecs[v].idx, acc, ok);
            bus.req_valid = '0;
            starts = 0; hold_ok = 1'b1; t = -1; t_start = -1;
            for (int k = 0; k < 100 && ok; k++) begin
                if (bus.add_start) begin
                    starts++;
                    if (t_start < 0) t_start = cyc - acc;
                end
                if (bus.add_in1 !== vecs[v].a || bus.add_in2 !== vecs[v].b) hold_ok = 1'b0;
                if (bus.resp_valid != '0) begin
                    t = cyc - acc;
                    break;
                end
                tick();
            end
            chk($sformatf("v%0d_start_lat", v), t_start, 1);
            chk($sformatf("v%0d_start_cnt", v), starts, 1);
            chk($sformatf("v%0d_resp_lat", v), t, 8);
            chk($sformatf("v%0d_operand_hold", v), hold_ok, 1);
            chk($sformatf("v%0d_resp_valid", v), bus.resp_valid, onehot(vecs[v].idx));
            chk($sformatf("v%0d_result", v), bus.resp_result, vecs[v].r);
            chk($sformatf("v%0d_inf", v), bus.resp_inf, vecs[v].inf);
            chk($sformatf("v%0d_zero", v), bus.resp_zero, vecs[v].zero);
            chk($sformatf("v%0d_err", v), bus.resp_err, 0);
            bus.resp_ready = onehot(vecs[v].idx);
            tick();
            bus.resp_ready = '0;
            chk($sformatf("v%0d_resp_clear", v), bus.resp_valid, 0);
        end

        // Back-to-back with resp_ready held high.
        do_reset();
        bus.resp_ready = '1;
        set_req(0, 32'h5AD9_A053, 32'hB36A_8CB6);
        set_req(1, 32'hFDEF_5956, 32'hB1F6_85E1);
        wait_accept(0, acc, ok);
        bus.req_valid[0] = 1'b0;
        hs = -1; r0 = '0;
        for (int k = 0; k < 100; k++) begin
            if (bus.resp_valid[0]) begin
                hs = cyc;
                r0 = bus.resp_result;
                break;
            end
            tick();
        end
        chk("b2b_result0", r0, 32'h5768_8701);
        tick();
        wait_accept(1, acc2, ok);
        chk("b2b_gap", acc2 - hs, 1);
        bus.req_valid[1] = 1'b0;
        wait_resp(t);
        chk("b2b_resp_valid1", bus.resp_valid, onehot(1));
        chk("b2b_result1", bus.resp_result, 32'hB1F6_8599);
        tick();
        bus.resp_ready = '0;

        // Fairness: everyone valid continuously.
        do_reset();
        bus.resp_ready = '1;
        for (int i = 0; i < NR; i++) begin
            fa[i] = 32'h0100_0000 * (i + 1);
            fb[i] = 32'h0000_0011 * (i + 3);
            set_req(i, fa[i], fb[i]);
        end
        ngr = 0; multi = 1'b0;
        for (int k = 0; k < 400 && ngr < 8; k++) begin
            #1;
            if ($countones(bus.req_ready) > 1) multi = 1'b1;
            for (int j = 0; j < NR; j++) begin
                if (bus.req_ready[j] && ngr < 8) begin
                    order[ngr] = j;
                    ngr++;
                end
                if (bus.resp_valid[j]) chk($sformatf("fair_result_req%0d", j), bus.resp_result, stub_fn(fa[j], fb[j]));
            end
            tick();
        end
        chk("fair_grant_count", ngr, 8);
        chk("fair_multihot", multi, 0);
        for (int g = 0; g < 8; g++) chk($sformatf("fair_order%0d", g), order[g], g % NR);

        // Backpressure on requester 2 while requester 0 waits.
        do_reset();
        set_req(2, 32'h0000_1234, 32'h0000_4321);
        wait_accept(2, acc, ok);
        bus.req_valid = '0;
        set_req(0, 32'h0000_0001, 32'h0000_0001);
        bus.resp_ready = 4'b1011;
        wait_resp(t);
        r0 = bus.resp_result;
        chk("bp_result", r0, 32'h0000_5555);
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("bp_valid_hold", bus.resp_valid, 4'b0100);
            chk("bp_result_hold", bus.resp_result, r0);
            chk("bp_no_grant", bus.req_ready, 0);
            tick();
        end
        bus.resp_ready[2] = 1'b1;
        tick();
        bus.resp_ready = '0;
        #1;
        chk("bp_next_grant", bus.req_ready, 4'b0001);
        wait_accept(0, acc, ok);
        bus.req_valid = '0;
        wait_resp(t);
        chk("bp_next_result", bus.resp_result, 32'h0000_0002);
        bus.resp_ready = 4'b0001;
        tick();
        bus.resp_ready = '0;

`ifdef POSITADD_ARB_WATCHDOG_EN
        // Watchdog: adder never completes.
        do_reset();
        stub_hang = 1'b1;
        set_req(1, 32'h1111_1111, 32'h2222_2222);
        wait_accept(1, acc, ok);
        bus.req_valid = '0;
        wait_resp(t);
        chk("wd_latency", t - acc, MAX_LAT + 2);
        chk("wd_valid", bus.resp_valid, onehot(1));
        chk("wd_err", bus.resp_err, 1);
        chk("wd_result", bus.resp_result, NAR);
        chk("wd_inf", bus.resp_inf, 1);
        chk("wd_zero", bus.resp_zero, 0);
        bus.resp_ready = onehot(1);
        tick();
        bus.resp_ready = '0;
        chk("wd_err_clear", bus.resp_err, 0);
        stub_hang = 1'b0;
`endif

        // Reset while waiting on the adder; the late done must be ignored.
        do_reset();
        set_req(3, 32'h0000_0100, 32'h0000_0200);
        wait_accept(3, acc, ok);
        bus.req_valid = '0;
        tick();
        tick();
        bus.req_valid = '1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", bus.req_ready, 0);
        chk("mid_rst_add_start", bus.add_start, 0);
        chk("mid_rst_add_in1", bus.add_in1, 0);
        chk("mid_rst_add_in2", bus.add_in2, 0);
        chk("mid_rst_resp_valid", bus.resp_valid, 0);
        chk("mid_rst_resp_result", bus.resp_result, 0);
        chk("mid_rst_flags", {bus.resp_inf, bus.resp_zero, bus.resp_err}, 0);
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        late_bad = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (bus.resp_valid != '0 || bus.add_start) late_bad = 1'b1;
        end
        chk("mid_rst_late_done_ignored", late_bad, 0);

        // Randomized traffic against a round-robin reference model.
        do_reset();
        ptr = 0;
        for (int it = 0; it < 40; it++) begin
            mask = NR'($urandom_range(0, (1 << NR) - 1));
            for (int i = 0; i < NR; i++) begin
                fa[i] = $urandom;
                fb[i] = $urandom;
                case ($urandom_range(0, 7))
                    0: fb[i] = -fa[i];
                    1: begin fa[i] = NAR; fb[i] = 32'h0; end
                    default: ;
                endcase
                bus.req_in1[i*N +: N] = fa[i];
                bus.req_in2[i*N +: N] = fb[i];
            end
            bus.req_valid = mask;
            #1;
            if (mask == '0) begin
                chk("rnd_idle_ready", bus.req_ready, 0);
                tick();
                continue;
            end
            w = -1;
            for (int k = 0; k < NR; k++) begin
                if (w < 0 && mask[(ptr + k) % NR]) w = (ptr + k) % NR;
            end
            chk($sformatf("rnd%0d_grant", it), bus.req_ready, onehot(w));
            tick();
            bus.req_valid = '0;
            ea = fa[w];
            eb = fb[w];
            er = stub_fn(ea, eb);
            wait_resp(t);
            chk($sformatf("rnd%0d_resp_valid", it), bus.resp_valid, onehot(w));
            chk($sformatf("rnd%0d_result", it), bus.resp_result, er);
            chk($sformatf("rnd%0d_flags", it), {bus.resp_inf, bus.resp_zero, bus.resp_err},
                {er == NAR, er == 32'h0, 1'b0});
            d = $urandom_range(0, 3);
            for (int k = 0; k < d; k++) begin
                bus.resp_ready = NR'($urandom_range(0, (1 << NR) - 1)) & ~onehot(w);
                tick();
                chk($sformatf("rnd%0d_resp_hold", it), bus.resp_valid, onehot(w));
            end
            bus.resp_ready = onehot(w);
            tick();
            bus.resp_ready = '0;
            chk($sformatf("rnd%0d_resp_clear", it), bus.resp_valid, 0);
            ptr = (w + 1) % NR;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, nmis=%0d", nmis);
        $fatal(1);
    end
endmodule

// File: doc/positadd_arbiter.md
# positadd_arbiter

Shares one posit adder (`positadd`: `in1`/`in2`/`start` in, `result`/`inf`/`zero`/`done` out) between `NUM_REQ` requesters in the PairHMM posit datapath. Requesters use valid/ready handshakes. The block grants one request at a time in round-robin order, launches the adder, waits for `done`, and returns the result with `inf`/`zero` flags to the granted requester. Only one operation is in flight at a time.

## Interface
- `N`, 32, posit width
- `ES`, 2, posit exponent size (passed through for consistency; unused in logic)
- `NUM_REQ`, 4, number of requesters (2..8)
- `MAX_LAT`, 64, watchdog limit in cycles (used only with the watchdog macro)

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous reset, active low
- `req_valid`  in  NUM_REQ  per-requester request valid
- `req_ready`  out  NUM_REQ  per-requester accept (one-hot or zero)
- `req_in1`  in  NUM_REQ*N  operand 1, requester i at bits [i*N +: N]
- `req_in2`  in  NUM_REQ*N  operand 2, same packing
- `resp_valid`  out  NUM_REQ  result valid (one-hot or zero)
- `resp_ready`  in  NUM_REQ  requester accepts result
- `resp_result`  out  N  shared result bus
- `resp_inf`, `resp_zero`  out  1 each  result flags
- `resp_err`  out  1  watchdog abort flag (constant 0 without the watchdog macro)
- `add_in1`, `add_in2`  out  N each  adder operands
- `add_start`  out  1  adder launch
- `add_result`  in  N  adder result
- `add_inf`, `add_zero`, `add_done`  in  1 each  adder outputs

## Operation
- FSM states: `IDLE`, `ISSUE`, `WAIT`, `RESP`.
- `IDLE`:
  - Round-robin pick among `req_valid`, searching from `rr_ptr`.
  - `req_ready[g]` is combinationally high for the winner only.
  - On the handshake, latch the operands and grant index `g`, set `rr_ptr = (g+1) mod NUM_REQ`, and go to `ISSUE`.
- `ISSUE`: `add_start = 1` for exactly one cycle, then go to `WAIT`.
- `WAIT`: `add_in1`/`add_in2` hold the latched operands the whole time. On `add_done`, capture result and flags, go to `RESP`.
- `RESP`: `resp_valid[g] = 1` with registered result and flags. Hold until `resp_ready[g]`, then go to `IDLE`. `resp_ready` on other bits is ignored.
- `add_done` outside `WAIT` is ignored.
- `req_ready` is 0 in every state except `IDLE`, so there is at most one outstanding operation.
- A requester may drop `req_valid` before it is granted without side effect.

## Timing
- Reset values:
  - state `IDLE`, `rr_ptr = 0`
  - `add_start = 0`, `add_in1 = add_in2 = 0`
  - `resp_valid = 0`, `resp_result = 0`, `resp_inf = resp_zero = resp_err = 0`
  - `req_ready` derives from state, so it is 0 while `rst_n` is low
- Latency: accept at cycle T, `add_start` at T+1, result captured on the cycle `add_done` is seen, `resp_valid` from the next cycle. Overhead is 3 cycles plus adder latency.
- Back-to-back: the next grant can occur the cycle after the `resp_ready` handshake.
- Reset mid-operation: an in-flight adder result is discarded. A `done` arriving after reset is ignored because the FSM is in `IDLE`.
- All valid simultaneously: grant order is 0,1,2,3,0,... Each requester is served at least once every `NUM_REQ` grants.

## Configuration
- `POSITADD_ARB_WATCHDOG_EN` defined:
  - A counter runs in `WAIT`.
  - If `add_done` has not arrived after `MAX_LAT` cycles, go to `RESP` with `resp_result = 0x80000000` (NaR for N=32; generally `1 << (N-1)`) and `resp_err = 1`, `inf = 1`, `zero = 0`.
  - `resp_err` clears when the response handshake completes.
- Undefined: no counter, `resp_err` is tied to 0, and `WAIT` is unbounded.

## Structure
- Package `posit_arb_pkg`: state enum `arb_state_t`, `NAR_PATTERN` function of N, grant-index width `$clog2(NUM_REQ)`.
- Sub-module `rr_arbiter`: combinational round-robin pick from `req_valid` and `rr_ptr`; outputs one-hot grant and index. The pointer register stays in the top module.

## Test plan
Use a stub adder model with fixed latency L=4 returning the vectors below. Checks 1–4 run with the watchdog macro undefined; check 5 requires `POSITADD_ARB_WATCHDOG_EN` defined.
1. Single request: req0 with 0x5AD9A053 + 0xB36A8CB6 → `add_start` one cycle after accept; `resp_valid[0]` with 0x57688701, inf=0, zero=0, 8 cycles after accept (3 cycles overhead + L=4, plus the capture cycle).
2. Back-to-back: req1 with 0xFDEF5956 + 0xB1F685E1 → 0xB1F68599; with `resp_ready` held high, the next accept lands exactly 1 cycle after the response handshake.
3. Fairness: all four valid continuously for 8 ops → grant order 0,1,2,3,0,1,2,3; `req_ready` is never multi-hot.
4. Backpressure: hold `resp_ready[2] = 0` for 10 cycles → `resp_valid[2]` and the result stay stable; no new grant.
5. Watchdog (`POSITADD_ARB_WATCHDOG_EN` defined): stub never asserts `done` → after `MAX_LAT` cycles, `resp_err = 1`, result 0x80000000.
6. Reset in `WAIT`: assert `rst_n = 0` mid-operation → all outputs return to reset values immediately; a late `add_done` produces no `resp_valid`.
